// File: rtl/param_alu.sv
// Parametrised ALU with start/done handshake and a configurable-latency MUL/MAC path.
// Optional flag outputs (flag_zero, flag_carry) are built when PARAM_ALU_FLAGS_EN is defined.
module param_alu #(
   parameter int WIDTH      = 8,
   parameter int MUL_STAGES = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [2:0]           op,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic                 acc_clr,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [2*WIDTH-1:0]   result
`ifdef PARAM_ALU_FLAGS_EN
   ,
   output logic                 flag_zero,
   output logic                 flag_carry
`endif
);

   localparam int W2 = 2 * WIDTH;
   localparam int CW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
`ifdef PARAM_ALU_FLAGS_EN
   localparam int SW = W2 + 1;
`else
   localparam int SW = W2;
`endif

   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;
   localparam logic [2:0] OP_OR  = 3'b110;
   localparam logic [2:0] OP_MAC = 3'b111;

   typedef enum logic {IDLE, MULT} state_t;

   state_t           state_reg, state_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [WIDTH-1:0] a_reg, a_next, b_reg, b_next;
   logic             mac_reg, mac_next;
   logic [W2-1:0]    acc_reg, acc_next;
   logic [W2-1:0]    result_reg, result_next;
   logic             done_reg, done_next, err_reg, err_next;

   logic [W2-1:0]    a_ext, b_ext, mul_a, mul_b, prod, acc_base, res_val;
   logic [SW-1:0]    mac_sum;
   logic             complete, mul_done, is_mac;
`ifdef PARAM_ALU_FLAGS_EN
   logic             carry_val;
   logic             zero_reg, zero_next, carry_reg, carry_next;
`endif

   assign a_ext = W2'(A);
   assign b_ext = W2'(B);

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      a_next      = a_reg;
      b_next      = b_reg;
      mac_next    = mac_reg;
      acc_next    = acc_reg;
      result_next = result_reg;
      done_next   = 1'b0;
      err_next    = 1'b0;
      complete    = 1'b0;
      mul_done    = 1'b0;
      res_val     = '0;
      mul_a       = W2'(a_reg);
      mul_b       = W2'(b_reg);
      acc_base    = acc_reg;
      is_mac      = mac_reg;
`ifdef PARAM_ALU_FLAGS_EN
      carry_val   = 1'b0;
      zero_next   = zero_reg;
      carry_next  = carry_reg;
`endif
      case (state_reg)
         IDLE: begin
            // A clear coincident with a MAC start makes that MAC accumulate from zero.
            if (acc_clr) begin
               acc_next = '0;
               acc_base = '0;
            end
            if (start) begin
               case (op)
                  OP_ADD: begin
                     complete = 1'b1;
                     res_val  = a_ext + b_ext;
`ifdef PARAM_ALU_FLAGS_EN
                     carry_val = res_val[WIDTH];
`endif
                  end
                  OP_SUB: begin
                     complete = 1'b1;
                     res_val  = a_ext - b_ext;
`ifdef PARAM_ALU_FLAGS_EN
                     carry_val = (A < B);
`endif
                  end
                  OP_AND: begin complete = 1'b1; res_val = a_ext & b_ext; end
                  OP_XOR: begin complete = 1'b1; res_val = a_ext ^ b_ext; end
                  OP_OR:  begin complete = 1'b1; res_val = a_ext | b_ext; end
                  OP_MUL, OP_MAC: begin
                     is_mac = (op == OP_MAC);
                     if (MUL_STAGES == 1) begin
                        mul_a    = a_ext;
                        mul_b    = b_ext;
                        complete = 1'b1;
                        mul_done = 1'b1;
                     end else begin
                        a_next     = A;
                        b_next     = B;
                        mac_next   = is_mac;
                        cnt_next   = CW'(MUL_STAGES - 1);
                        state_next = MULT;
                     end
                  end
                  default: ;
               endcase
            end
         end
         MULT: begin
            if (start)
               err_next = 1'b1;
            if (cnt_reg == CW'(1)) begin
               complete   = 1'b1;
               mul_done   = 1'b1;
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg - CW'(1);
            end
         end
         default: state_next = IDLE;
      endcase

      prod    = mul_a * mul_b;
      mac_sum = SW'(acc_base) + SW'(prod);
      if (mul_done) begin
         if (is_mac) begin
            res_val  = mac_sum[W2-1:0];
            acc_next = mac_sum[W2-1:0];
`ifdef PARAM_ALU_FLAGS_EN
            carry_val = mac_sum[W2];
`endif
         end else begin
            res_val = prod;
         end
      end

      if (complete) begin
         result_next = res_val;
         done_next   = 1'b1;
`ifdef PARAM_ALU_FLAGS_EN
         zero_next   = (res_val == '0);
         carry_next  = carry_val;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         mac_reg    <= 1'b0;
         acc_reg    <= '0;
         result_reg <= '0;
         done_reg   <= 1'b0;
         err_reg    <= 1'b0;
`ifdef PARAM_ALU_FLAGS_EN
         zero_reg   <= 1'b0;
         carry_reg  <= 1'b0;
`endif
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         a_reg      <= a_next;
         b_reg      <= b_next;
         mac_reg    <= mac_next;
         acc_reg    <= acc_next;
         result_reg <= result_next;
         done_reg   <= done_next;
         err_reg    <= err_next;
`ifdef PARAM_ALU_FLAGS_EN
         zero_reg   <= zero_next;
         carry_reg  <= carry_next;
`endif
      end
   end

   assign busy   = (state_reg == MULT);
   assign done   = done_reg;
   assign err    = err_reg;
   assign result = result_reg;
`ifdef PARAM_ALU_FLAGS_EN
   assign flag_zero  = zero_reg;
   assign flag_carry = carry_reg;
`endif

endmodule

// File: tb/tb_param_alu.sv
// Self-checking bench for param_alu (WIDTH=8, MUL_STAGES=3): directed steps from the
// test plan followed by random traffic, compared cycle by cycle against a behavioural model.
module tb_param_alu;

   localparam int WIDTH      = 8;
   localparam int MUL_STAGES = 3;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic [2:0]        op = 3'b000;
   logic [WIDTH-1:0]  A = '0;
   logic [WIDTH-1:0]  B = '0;
   logic              acc_clr = 1'b0;
   logic              busy, done, err;
   logic [2*WIDTH-1:0] result;

   int errors = 0;
   int checks = 0;
   int step_no = 0;

   // reference model state
   int          m_left = 0;
   logic [15:0] m_pending = '0;
   logic        m_pend_mac = 1'b0;
   logic [15:0] m_acc = '0;
   logic [15:0] m_result = '0;
   logic        m_done = 1'b0;
   logic        m_err = 1'b0;

   param_alu #(.WIDTH(WIDTH), .MUL_STAGES(MUL_STAGES)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
      .acc_clr(acc_clr), .busy(busy), .done(done), .err(err), .result(result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s step=%0d got=0x%0h exp=0x%0h", tag, step_no, got, exp);
      end
   endtask

   task automatic check_outputs();
      chk("busy",   32'(busy),   32'(m_left > 0));
      chk("done",   32'(done),   32'(m_done));
      chk("err",    32'(err),    32'(m_err));
      chk("result", 32'(result), 32'(m_result));
   endtask

   // Model of one clock edge given the inputs presented to it.
   task automatic model_edge(input logic s, input logic [2:0] o, input logic [7:0] a,
                             input logic [7:0] b, input logic clr);
      logic [15:0] a16, b16;
      a16 = 16'(a);
      b16 = 16'(b);
      m_done = 1'b0;
      m_err  = 1'b0;
      if (m_left > 0) begin
         if (s) m_err = 1'b1;
         m_left--;
         if (m_left == 0) begin
            m_done   = 1'b1;
            m_result = m_pending;
            if (m_pend_mac) m_acc = m_pending;
         end
      end else begin
         if (clr) m_acc = '0;
         if (s) begin
            case (o)
               3'd1: begin m_done = 1'b1; m_result = a16 + b16; end
               3'd2: begin m_done = 1'b1; m_result = a16 & b16; end
               3'd3: begin m_done = 1'b1; m_result = a16 ^ b16; end
               3'd5: begin m_done = 1'b1; m_result = a16 - b16; end
               3'd6: begin m_done = 1'b1; m_result = a16 | b16; end
               3'd4: begin m_pending = a16 * b16; m_pend_mac = 1'b0; m_left = MUL_STAGES - 1; end
               3'd7: begin m_pending = m_acc + a16 * b16; m_pend_mac = 1'b1; m_left = MUL_STAGES - 1; end
               default: ;
            endcase
         end
      end
   endtask

   task automatic step(input logic s, input logic [2:0] o, input logic [7:0] a,
                       input logic [7:0] b, input logic clr);
      start = s; op = o; A = a; B = b; acc_clr = clr;
      @(posedge clk);
      #1;
      step_no++;
      model_edge(s, o, a, b, clr);
      check_outputs();
      $display("step %0d start=%0b op=%0d A=%02h B=%02h clr=%0b -> busy=%0b done=%0b err=%0b result=%04h",
               step_no, s, o, a, b, clr, busy, done, err, result);
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; acc_clr = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      step_no++;
      m_left = 0; m_acc = '0; m_result = '0; m_done = 1'b0; m_err = 1'b0;
      check_outputs();
      $display("step %0d reset -> busy=%0b done=%0b err=%0b result=%04h", step_no, busy, done, err, result);
   endtask

   initial begin
      do_reset();
      // ADD with carry into bit WIDTH
      step(1, 3'd1, 8'hFF, 8'h01, 0);
      chk("add_result", 32'(result), 32'h0100);
      step(0, 3'd0, 8'h00, 8'h00, 0);
      // full-width MUL latency
      step(1, 3'd4, 8'hFF, 8'hFF, 0);
      step(0, 3'd0, 8'h00, 8'h00, 0);
      step(0, 3'd0, 8'h00, 8'h00, 0);
      chk("mul_result", 32'(result), 32'hFE01);
      // start while busy is rejected; in-flight op keeps its operands
      step(1, 3'd4, 8'hFF, 8'hFF, 0);
      step(1, 3'd1, 8'h11, 8'h22, 0);
      step(0, 3'd0, 8'h00, 8'h00, 0);
      chk("busy_reject_result", 32'(result), 32'hFE01);
      step(0, 3'd0, 8'h00, 8'h00, 0);
      // MAC chain with acc_clr at start and acc_clr ignored while busy
      step(1, 3'd7, 8'h10, 8'h10, 1);
      step(0, 3'd0, 8'h00, 8'h00, 0);
      step(0, 3'd0, 8'h00, 8'h00, 0);
      chk("mac1", 32'(result), 32'h0100);
      step(1, 3'd7, 8'h02, 8'h03, 0);
      step(0, 3'd0, 8'h00, 8'h00, 1);
      step(0, 3'd0, 8'h00, 8'h00, 0);
      chk("mac2", 32'(result), 32'h0106);
      // SUB underflow then NOP
      step(1, 3'd5, 8'h05, 8'h07, 0);
      chk("sub", 32'(result), 32'hFFFE);
      step(1, 3'd0, 8'h12, 8'h34, 0);
      chk("nop_hold", 32'(result), 32'hFFFE);
      // reset drops an in-flight MUL
      step(1, 3'd4, 8'h12, 8'h34, 0);
      do_reset();
      for (int i = 0; i < 3; i++) step(0, 3'd0, 8'h00, 8'h00, 0);
      // random traffic, including starts in the done cycle and starts while busy
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 7) == 0));
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
